// File: rtl/dsm_integrator_sequencer.sv
// dsm_integrator_sequencer
//   Time-multiplexed controller for an NSTAGE delta-sigma integrator chain.
//   One shared adder walks the stages from NSTAGE-1 down to 0 each sample, so every stage
//   reads the previous-sample value of the stage before it (delaying integrators).
//   The 1-bit quantizer output drives the DAC pin.
//   Optional build macro: DSM_STAGE_CLIP_EN. When defined, stage results saturate to +/-2^(W-2)
//   and set the sticky clip flag. When undefined, results wrap modulo 2^W and clip is tied 0.
module dsm_integrator_sequencer #(
  parameter int unsigned NSTAGE = 6,
  parameter int unsigned W      = 36,
  parameter int unsigned FS_DIV = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x_in,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [2:0]   coef_idx,
  input  logic [W-1:0] coef_data,
  output logic         y_bit,
  output logic         y_valid,
  input  logic         clr_flags,
  output logic         underrun,
  output logic         clip
);

  localparam int unsigned DW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} fsm_t;

  fsm_t                fsm_q;
  logic [DW-1:0]       div_cnt;
  logic                strobe;
  logic [2:0]          k_q;
  logic signed [W-1:0] x_lat;
  logic signed [W-1:0] state_q [NSTAGE];
  logic signed [W-1:0] cur;
  logic signed [W-1:0] src;
  logic signed [W-1:0] res;

  assign strobe   = en && (div_cnt == DW'(FS_DIV - 1));
  assign coef_idx = k_q;

  // Sample-rate divider: free-runs while enabled, parked at 0 while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Operand select: current stage and its source (input sample for stage 0)
  always_comb begin
    cur = '0;
    src = x_lat;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (k_q == 3'(i)) cur = state_q[i];
      if ((i + 1 < NSTAGE) && (k_q == 3'(i + 1))) src = state_q[i];
    end
  end

`ifdef DSM_STAGE_CLIP_EN
  localparam logic signed [W+1:0] POS_LIM = {3'b000, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [W+1:0] NEG_LIM = -POS_LIM;

  logic signed [W+1:0] coef_ext;
  logic signed [W+1:0] fb_ext;
  logic signed [W+1:0] sum_ext;
  logic                sat;
  logic                clip_q;

  // Shared adder with W+2 bit headroom, saturating to +/-2^(W-2)
  always_comb begin
    coef_ext = {{2{coef_data[W-1]}}, coef_data};
    fb_ext   = y_bit ? -coef_ext : coef_ext;
    sum_ext  = {{2{cur[W-1]}}, cur} + {{2{src[W-1]}}, src} + fb_ext;
    sat      = 1'b0;
    res      = sum_ext[W-1:0];
    if (sum_ext > POS_LIM) begin
      res = POS_LIM[W-1:0];
      sat = 1'b1;
    end else if (sum_ext < NEG_LIM) begin
      res = NEG_LIM[W-1:0];
      sat = 1'b1;
    end
  end

  // Sticky clip flag; a saturation in the same cycle as clr_flags keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_q <= 1'b0;
    end else begin
      clip_q <= (clip_q && !clr_flags) || ((fsm_q == S_RUN) && sat);
    end
  end

  assign clip = clip_q;
`else
  logic signed [W-1:0] fb_w;

  // Shared adder, wrapping modulo 2^W (W-bit sum equals the low bits of the wide sum)
  always_comb begin
    fb_w = y_bit ? -coef_data : coef_data;
    res  = cur + src + fb_w;
  end

  assign clip = 1'b0;
`endif

  // Sequencer FSM: IDLE -> LOAD -> RUN (NSTAGE cycles) -> DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= S_IDLE;
      k_q      <= '0;
      x_lat    <= '0;
      x_ready  <= 1'b0;
      y_bit    <= 1'b0;
      y_valid  <= 1'b0;
      underrun <= 1'b0;
      for (int unsigned i = 0; i < NSTAGE; i++) state_q[i] <= '0;
    end else begin
      x_ready  <= 1'b0;
      y_valid  <= 1'b0;
      underrun <= underrun && !clr_flags;
      case (fsm_q)
        S_IDLE: begin
          if (strobe) fsm_q <= S_LOAD;
        end
        S_LOAD: begin
          if (x_valid) begin
            x_lat   <= x_in;
            x_ready <= 1'b1;
          end else begin
            x_lat    <= '0;
            underrun <= 1'b1;
          end
          k_q   <= 3'(NSTAGE - 1);
          fsm_q <= S_RUN;
        end
        S_RUN: begin
          for (int unsigned i = 0; i < NSTAGE; i++) begin
            if (k_q == 3'(i)) state_q[i] <= res;
          end
          if (k_q == 3'd0) begin
            // Last stage was finished on the first RUN cycle, so the quantizer bit and its
            // strobe are registered here and are presented throughout DONE.
            y_bit   <= ~state_q[NSTAGE-1][W-1];
            y_valid <= 1'b1;
            fsm_q   <= S_DONE;
          end else begin
            k_q <= k_q - 3'd1;
          end
        end
        S_DONE: begin
          fsm_q <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_integrator_sequencer.sv
// tb_dsm_integrator_sequencer
//   Scoreboard bench: stimulus pushes hand-computed per-sample expectations, a monitor pops and
//   compares on every y_valid. Expectations follow DSM_STAGE_CLIP_EN when it is defined.
module tb_dsm_integrator_sequencer;
  localparam int unsigned NSTAGE = 6;
  localparam int unsigned W      = 36;
  localparam int unsigned FS_DIV = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] x_in;
  logic         x_valid;
  logic         x_ready;
  logic [2:0]   coef_idx;
  logic [W-1:0] coef_data;
  logic         y_bit;
  logic         y_valid;
  logic         clr_flags;
  logic         underrun;
  logic         clip;

  logic [W-1:0] coef_rom [8];
  assign coef_data = coef_rom[coef_idx];

  always #5 clk = ~clk;

  dsm_integrator_sequencer #(.NSTAGE(NSTAGE), .W(W), .FS_DIV(FS_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_idx(coef_idx), .coef_data(coef_data), .y_bit(y_bit), .y_valid(y_valid),
    .clr_flags(clr_flags), .underrun(underrun), .clip(clip)
  );

  typedef struct {
    logic         y;
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    int           xr;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   xr_cnt = 0;
  int   xr_cyc = 0;
  int   yv_total = 0;
  int   last_yv = 0;
  int   en_rise = 0;
  bit   spc_chk = 0;
  bit   have_last = 0;
  bit   lat_chk = 0;

  localparam logic [W-1:0] A  = 36'h3_FFFF_FFFF;  // 2^(W-2)-1
  localparam logic [W-1:0] LIM = 36'h4_0000_0000; // 2^(W-2)
`ifdef DSM_STAGE_CLIP_EN
  localparam logic CLIP_EXP = 1'b1;
`else
  localparam logic CLIP_EXP = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic y, input logic [W-1:0] s0, input logic [W-1:0] s1, input int xr);
    exp_t e;
    e.y = y; e.s0 = s0; e.s1 = s1; e.xr = xr;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: counts x_ready pulses and checks each y_valid against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (x_ready) begin
      xr_cnt++;
      xr_cyc = cyc;
    end
    if (y_valid) begin
      yv_total++;
      if (sb.size() == 0) begin
        chk("unexpected_y_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("y_bit", 64'(y_bit), 64'(e.y));
        chk("state0", 64'($unsigned(dut.state_q[0])), 64'(e.s0));
        chk("state1", 64'($unsigned(dut.state_q[1])), 64'(e.s1));
        chk("x_ready_pulses", 64'(xr_cnt), 64'(e.xr));
        if (xr_cnt > 0) chk("xready_to_yvalid", 64'(cyc - xr_cyc), 64'(NSTAGE));
      end
      xr_cnt = 0;
      if (lat_chk) begin
        chk("strobe_latency", 64'(cyc - en_rise), 64'(FS_DIV - 1 + NSTAGE + 2));
        lat_chk = 0;
      end
      if (spc_chk && have_last) chk("y_valid_period", 64'(cyc - last_yv), 64'(FS_DIV));
      have_last = 1;
      last_yv = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    xr_cnt = 0;
    have_last = 0;
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic wait_xready(input int budget);
    int n;
    n = 0;
    while (!x_ready && n < budget) begin
      tick();
      n++;
    end
    if (!x_ready) chk("x_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_samples(input int n);
    en_rise = cyc;
    en = 1'b1;
    wait_drain(n * FS_DIV + 100);
    en = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < 8; i++) coef_rom[i] = '0;
    coef_rom[5] = 36'd7;
    rst = 1'b1; en = 1'b0; x_valid = 1'b1; x_in = 36'd5; clr_flags = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_x_ready", 64'(x_ready), 64'd0);
    chk("rst_coef_idx", 64'(coef_idx), 64'd0);
    chk("rst_y_bit", 64'(y_bit), 64'd0);
    chk("rst_y_valid", 64'(y_valid), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_clip", 64'(clip), 64'd0);
    rst = 1'b0;
    tick();

    // Test 1: reset asserted mid-RUN discards the partial sample
    en = 1'b1;
    wait_xready(200);
    tick();
    tick();
    chk("midrun_state5", 64'($unsigned(dut.state_q[5])), 64'd7);
    chk("midrun_coef_idx", 64'(coef_idx), 64'd3);
    rst = 1'b1;
    #1;
    chk("midrst_state5", 64'($unsigned(dut.state_q[5])), 64'd0);
    chk("midrst_coef_idx", 64'(coef_idx), 64'd0);
    chk("midrst_x_ready", 64'(x_ready), 64'd0);
    chk("midrst_y_valid", 64'(y_valid), 64'd0);
    chk("midrst_y_bit", 64'(y_bit), 64'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    xr_cnt = 0;
    have_last = 0;
    repeat (100) tick();
    coef_rom[5] = '0;

    // Test 2: zero input, zero coefficients -> y_bit 1 every FS_DIV cycles
    x_in = '0;
    push(1'b1, '0, '0, 1);
    push(1'b1, '0, '0, 1);
    push(1'b1, '0, '0, 1);
    lat_chk = 1; spc_chk = 1; have_last = 0;
    run_samples(3);
    spc_chk = 0;

    // Test 3: unit input shows delaying-integrator chain
    do_reset();
    x_in = 36'd1;
    push(1'b1, 36'd1, 36'd0, 1);
    push(1'b1, 36'd2, 36'd1, 1);
    push(1'b1, 36'd3, 36'd3, 1);
    run_samples(3);

    // Test 4: underrun, set beats clear in the same cycle
    do_reset();
    chk("underrun_pre", 64'(underrun), 64'd0);
    x_valid = 1'b0;
    x_in = 36'd9;
    push(1'b1, '0, '0, 0);
    en_rise = cyc;
    en = 1'b1;
    repeat (FS_DIV) tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("underrun_set_wins", 64'(underrun), 64'd1);
    wait_drain(100);
    en = 1'b0;
    tick();
    chk("underrun_sticky", 64'(underrun), 64'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("underrun_cleared", 64'(underrun), 64'd0);
    x_valid = 1'b1;

    // Test 5: large input, saturation or wrap
    do_reset();
    x_in = A;
`ifdef DSM_STAGE_CLIP_EN
    push(1'b1, A, '0, 1);
    push(1'b1, LIM, A, 1);
    push(1'b1, LIM, LIM, 1);
`else
    push(1'b1, A, '0, 1);
    push(1'b1, 36'h7_FFFF_FFFE, A, 1);
    push(1'b1, 36'hB_FFFF_FFFD, 36'hB_FFFF_FFFD, 1);
`endif
    run_samples(3);
    chk("clip_flag", 64'(clip), 64'(CLIP_EXP));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clip_cleared", 64'(clip), 64'd0);

    // Test 6: en dropped inside RUN -> exactly one sample completes
    do_reset();
    x_in = 36'd1;
    base = yv_total;
    push(1'b1, 36'd1, 36'd0, 1);
    en = 1'b1;
    wait_xready(200);
    tick();
    tick();
    en = 1'b0;
    wait_drain(100);
    repeat (200) tick();
    chk("en_drop_y_valid_count", 64'(yv_total - base), 64'd1);

    // Test 7: quantizer feedback sign through the coefficient ROM
    do_reset();
    coef_rom[5] = 36'd3;
    x_in = '0;
    push(1'b1, '0, '0, 1);
    push(1'b1, '0, '0, 1);
    push(1'b0, '0, '0, 1);
    push(1'b1, '0, '0, 1);
    run_samples(4);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
